lamp_ctrl_tester: RTL and testbench



---
 rtl/lamp_pkg.sv | 20 ++
 rtl/lamp_ctrl_tester_if.sv | 28 ++
 rtl/lamp_ctrl_tester_dwell_timer.sv | 41 ++++
 rtl/lamp_ctrl_tester.sv | 96 +++++++++
 tb/tb_lamp_ctrl_tester.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/lamp_pkg.sv
// lamp_pkg: shared definitions for the three-way lamp controller, its model
// and the switch->lamp stimulus/check engine.
//   state_e        : tester FSM states
//   NUM_CODES      : number of switch codes walked per run
//   lamp_expected  : lamp output a correct controller produces (odd parity)
package lamp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NUM_CODES = 8;

   function automatic logic lamp_expected(input logic s3, input logic s2, input logic s1);
      return s3 ^ s2 ^ s1;
   endfunction

endpackage

// File: rtl/lamp_ctrl_tester_if.sv
// lamp_ctrl_tester_if: bundle between the tester and its environment.
//   start    : level-sampled run request
//   F        : lamp output of the controller under test
//   S1..S3   : registered switch drives
//   busy/done/pass/err_cnt/fail_vec : run status and result summary
// master = tester side, slave = environment (controller + supervisor).
interface lamp_ctrl_tester_if;
   logic       start;
   logic       F;
   logic       S1;
   logic       S2;
   logic       S3;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_cnt;
   logic [7:0] fail_vec;

   modport master (
      input  start, F,
      output S1, S2, S3, busy, done, pass, err_cnt, fail_vec
   );

   modport slave (
      output start, F,
      input  S1, S2, S3, busy, done, pass, err_cnt, fail_vec
   );
endinterface

// File: rtl/lamp_ctrl_tester_dwell_timer.sv
// dwell_timer: counts the cycles a switch code has been held.
//   clk, rst   : clock, async active-high reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance; wraps to 0 after DWELL-1
//   at_sample  : count == SAMPLE (compare F this cycle)
//   at_last    : count == DWELL-1 (last cycle of this code)
module dwell_timer #(
   parameter int DWELL  = 50,
   parameter int SAMPLE = 49
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic at_sample,
   output logic at_last
);

   localparam int CW = $clog2(DWELL);
   localparam logic [CW-1:0] SAMPLE_C = CW'(SAMPLE);
   localparam logic [CW-1:0] LAST_C   = CW'(DWELL - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (en)
         count_d = (count_q == LAST_C) ? '0 : count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign at_sample = (count_q == SAMPLE_C);
   assign at_last   = (count_q == LAST_C);

endmodule

// File: rtl/lamp_ctrl_tester.sv
// lamp_ctrl_tester: walks {S3,S2,S1} through codes 0..7, holding each for
// DWELL cycles, compares F against odd parity once per code at dwell index
// SAMPLE and reports err_cnt / fail_vec / pass.
//   clk, rst : clock, async active-high reset (aborts a run, drops results)
//   bus      : master modport of lamp_ctrl_tester_if
module lamp_ctrl_tester
   import lamp_pkg::*;
#(
   parameter int DWELL  = 50,
   parameter int SAMPLE = 49
) (
   input  logic                  clk,
   input  logic                  rst,
   lamp_ctrl_tester_if.master    bus
);

   state_e     state_q, state_d;
   logic [2:0] pattern_q, pattern_d;
   logic [2:0] s_q, s_d;
   logic [3:0] err_cnt_q, err_cnt_d;
   logic [7:0] fail_vec_q, fail_vec_d;
   logic       tmr_clr, tmr_en;
   logic       at_sample, at_last;

   dwell_timer #(.DWELL(DWELL), .SAMPLE(SAMPLE)) u_dwell (
      .clk       (clk),
      .rst       (rst),
      .clr       (tmr_clr),
      .en        (tmr_en),
      .at_sample (at_sample),
      .at_last   (at_last)
   );

   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      err_cnt_d  = err_cnt_q;
      fail_vec_d = fail_vec_q;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d    = RUN;
               pattern_d  = '0;
               err_cnt_d  = '0;
               fail_vec_d = '0;
               tmr_clr    = 1'b1;
            end
         end
         RUN: begin
            tmr_en = 1'b1;
            // Compare uses the code currently on S, before any advance below.
            if (at_sample &&
                (bus.F != lamp_expected(pattern_q[2], pattern_q[1], pattern_q[0]))) begin
               fail_vec_d[pattern_q] = 1'b1;
               if (err_cnt_q != 4'(NUM_CODES))
                  err_cnt_d = err_cnt_q + 4'd1;
            end
            if (at_last) begin
               if (pattern_q == 3'd7) state_d   = DONE;
               else                   pattern_d = pattern_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // S is registered: load what the pattern will be in the next state.
      s_d = (state_d == RUN) ? pattern_d : 3'b000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pattern_q  <= '0;
         s_q        <= '0;
         err_cnt_q  <= '0;
         fail_vec_q <= '0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         s_q        <= s_d;
         err_cnt_q  <= err_cnt_d;
         fail_vec_q <= fail_vec_d;
      end
   end

   assign bus.S1       = s_q[0];
   assign bus.S2       = s_q[1];
   assign bus.S3       = s_q[2];
   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.pass     = (state_q == DONE) && (err_cnt_q == 4'd0);
   assign bus.err_cnt  = err_cnt_q;
   assign bus.fail_vec = fail_vec_q;

endmodule

// File: tb/tb_lamp_ctrl_tester.sv
module tb_lamp_ctrl_tester;

   localparam int DW = 4;
   localparam int SP = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ctrl_tbl;   // F produced by the controller model for each code
   int         n_chk  = 0;
   int         n_pass = 0;

   lamp_ctrl_tester_if bus();

   lamp_ctrl_tester #(.DWELL(DW), .SAMPLE(SP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   assign bus.F = ctrl_tbl[{bus.S3, bus.S2, bus.S1}];

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: a code fails when the controller's F differs from odd parity.
   function automatic logic [7:0] exp_fail(input logic [7:0] tbl);
      logic [7:0] fv = '0;
      for (int c = 0; c < 8; c++)
         fv[c] = tbl[c] != logic'($countones(c) % 2);
      return fv;
   endfunction

   function automatic logic [2:0] s_now();
      return {bus.S3, bus.S2, bus.S1};
   endfunction

   // Called at a negedge. Start sampled at the next edge k; returns at the
   // negedge after edge k+8*DW with results checked.
   task automatic run_check(input string tag, input bit hold);
      logic [7:0] fv;
      fv = exp_fail(ctrl_tbl);
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);
      if (!hold) bus.start = 1'b0;
      chk({tag, "_s0"}, 32'(s_now()), 32'd0);
      chk({tag, "_busy0"}, 32'(bus.busy), 32'd1);
      for (int e = 1; e <= 8 * DW; e++) begin
         @(posedge clk); @(negedge clk);
         if (e < 8 * DW && e % DW == 0)
            chk({tag, "_s"}, 32'(s_now()), 32'(e / DW));
         if (e == 8 * DW - 1)
            chk({tag, "_notdone"}, 32'(bus.done), 32'd0);
      end
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_sidle"}, 32'(s_now()), 32'd0);
      chk({tag, "_fv"}, 32'(bus.fail_vec), 32'(fv));
      chk({tag, "_err"}, 32'(bus.err_cnt), 32'($countones(fv)));
      chk({tag, "_pass"}, 32'(bus.pass), 32'(fv == 8'h00));
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      ctrl_tbl  = 8'h96;
      #12;
      chk("rst_s", 32'(s_now()), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_pass", 32'(bus.pass), 32'd0);
      chk("rst_err", 32'(bus.err_cnt), 32'd0);
      chk("rst_fv", 32'(bus.fail_vec), 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // Correct XOR controller
      ctrl_tbl = 8'h96;
      run_check("xor", 1'b0);
      chk("xor_fv_const", 32'(bus.fail_vec), 32'h00);

      // F stuck at 0, then restart from DONE with a correct controller
      ctrl_tbl = 8'h00;
      run_check("stk0", 1'b0);
      chk("stk0_fv_const", 32'(bus.fail_vec), 32'h96);
      repeat (3) @(negedge clk);
      chk("done_held", 32'(bus.done), 32'd1);
      ctrl_tbl = 8'h96;
      run_check("b2b", 1'b0);

      // Inverted controller
      ctrl_tbl = 8'h69;
      run_check("xnor", 1'b0);
      chk("xnor_err_const", 32'(bus.err_cnt), 32'd8);

      // start held through the run: no restart, then re-entry from DONE
      ctrl_tbl = 8'h00;
      run_check("hold", 1'b1);
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      chk("hold_rerun_busy", 32'(bus.busy), 32'd1);
      chk("hold_rerun_done", 32'(bus.done), 32'd0);
      chk("hold_rerun_err", 32'(bus.err_cnt), 32'd0);
      chk("hold_rerun_fv", 32'(bus.fail_vec), 32'd0);

      // Reset in the middle of a run aborts immediately
      rst = 1'b1; #1; rst = 1'b0;
      @(negedge clk);
      ctrl_tbl  = 8'h00;
      bus.start = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      repeat (12) begin @(posedge clk); @(negedge clk); end
      chk("mid_err", 32'(bus.err_cnt), 32'd2);
      chk("mid_s", 32'(s_now()), 32'd3);
      rst = 1'b1;
      #1;
      chk("abort_s", 32'(s_now()), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_err", 32'(bus.err_cnt), 32'd0);
      chk("abort_fv", 32'(bus.fail_vec), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      ctrl_tbl = 8'h96;
      run_check("post_rst", 1'b0);

      // Randomly faulty controllers
      for (int r = 0; r < 4; r++) begin
         ctrl_tbl = 8'($urandom);
         run_check("rand", 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
